// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and stall-vector encodings for the pipeline sequencer.
// Stall bit order is {wb,mem,ex,id,if,pc}; bit0 freezes the PC.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_IF   = 6'b000011;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_STALL = 2'd1,
    CTRL_FLUSH = 2'd2
  } ctrl_state_t;

  // Later stages win: freezing a later stage must also freeze everything upstream.
  function automatic stall_bus_t stall_encode(input logic if_req, input logic id_req,
                                              input logic ex_req, input logic mem_req);
    if (mem_req)     return STALL_MEM;
    else if (ex_req) return STALL_EX;
    else if (id_req) return STALL_ID;
    else if (if_req) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline stages (master) and the sequencer (slave).
interface pipe_stall_ctrl_if;
  import pipe_stall_ctrl_pkg::*;

  logic        if_stallreq_i;
  logic        id_stallreq_i;
  logic        ex_stallreq_i;
  logic        mem_stallreq_i;
  logic        flush_req_i;
  logic [31:0] new_pc_i;

  stall_bus_t  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_timeout_o;
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_count_o;

  modport master (
    output if_stallreq_i, id_stallreq_i, ex_stallreq_i, mem_stallreq_i, flush_req_i, new_pc_i,
    input  stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cycles_o, flush_count_o
  );

  modport slave (
    input  if_stallreq_i, id_stallreq_i, ex_stallreq_i, mem_stallreq_i, flush_req_i, new_pc_i,
    output stall_o, flush_o, new_pc_o, stall_timeout_o, stall_cycles_o, flush_count_o
  );

endinterface

// File: rtl/pipe_stall_ctrl_perf_cnt.sv
// Wrapping 32-bit performance counters for stall cycles and accepted flushes.
// Only instantiated when STALL_PERF_CNT_EN is defined.
module pipe_stall_ctrl_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_active,
  input  logic        flush_accept,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_active) stall_cycles <= stall_cycles + 32'd1;
      if (flush_accept) flush_count  <= flush_count + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges stage stall requests, sequences flushes, runs a stall watchdog.
// Optional perf counters are built when STALL_PERF_CNT_EN is defined.
//
//  state      | meaning
//  CTRL_IDLE  | no stall request, pipeline advancing
//  CTRL_STALL | at least one stage requesting a stall
//  CTRL_FLUSH | clearing pipeline registers, PC redirected, requests ignored
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int FLUSH_LEN     = 2,
  parameter int STALL_TIMEOUT = 1024,
  parameter int CNT_W         = 11
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  bus
);

  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT   = CNT_W'(STALL_TIMEOUT);

  ctrl_state_t      state;
  logic [3:0]       flush_cnt;
  logic             flush_q;
  logic [31:0]      new_pc_q;
  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_q;
  stall_bus_t       stall_req;
  stall_bus_t       stall_vec;
  logic             stall_active;

  assign stall_req    = stall_encode(bus.if_stallreq_i, bus.id_stallreq_i,
                                     bus.ex_stallreq_i, bus.mem_stallreq_i);
  assign stall_vec    = (state == CTRL_FLUSH) ? STALL_NONE : stall_req;
  assign stall_active = (stall_vec != STALL_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CTRL_IDLE;
      flush_cnt <= '0;
      flush_q   <= 1'b0;
      new_pc_q  <= ZERO_WORD;
    end else begin
      case (state)
        CTRL_IDLE, CTRL_STALL: begin
          if (bus.flush_req_i) begin
            state     <= CTRL_FLUSH;
            flush_cnt <= FLUSH_LOAD;
            flush_q   <= 1'b1;
            new_pc_q  <= bus.new_pc_i;
          end else if (stall_req != STALL_NONE) begin
            state <= CTRL_STALL;
          end else begin
            state <= CTRL_IDLE;
          end
        end
        CTRL_FLUSH: begin
          // Down-counter; terminal count ends the flush, late flush requests are dropped.
          if (flush_cnt == 4'd0) begin
            state    <= CTRL_IDLE;
            flush_q  <= 1'b0;
            new_pc_q <= ZERO_WORD;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state    <= CTRL_IDLE;
          flush_q  <= 1'b0;
          new_pc_q <= ZERO_WORD;
        end
      endcase
    end
  end

  // Watchdog counts consecutive stalled cycles; stall_vec is already zero during FLUSH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (!stall_active) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_LIMIT) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_LIMIT - 1'b1) timeout_q <= 1'b1;
    end
  end

  assign bus.stall_o         = stall_vec;
  assign bus.flush_o         = flush_q;
  assign bus.new_pc_o        = new_pc_q;
  assign bus.stall_timeout_o = timeout_q;

`ifdef STALL_PERF_CNT_EN
  logic        flush_accept;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  assign flush_accept = bus.flush_req_i && (state != CTRL_FLUSH);

  pipe_stall_ctrl_perf_cnt u_stall_perf_cnt (
    .clk          (clk),
    .rst          (rst),
    .stall_active (stall_active),
    .flush_accept (flush_accept),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  assign bus.stall_cycles_o = stall_cycles;
  assign bus.flush_count_o  = flush_count;
`else
  assign bus.stall_cycles_o = ZERO_WORD;
  assign bus.flush_count_o  = ZERO_WORD;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;
  import pipe_stall_ctrl_pkg::*;

  localparam int FLUSH_LEN     = 2;
  localparam int STALL_TIMEOUT = 16;
  localparam int CNT_W         = 5;
`ifdef STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_stall_ctrl_if bus();

  pipe_stall_ctrl #(
    .FLUSH_LEN     (FLUSH_LEN),
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .CNT_W         (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [31:0] pc;
    logic [31:0] tmo;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_valid = 1'b0;
  int          m_flush_left = 0;
  int          m_run = 0;
  bit          m_tmo = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_sc = '0;
  logic [31:0] m_fc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, push this cycle's expected outputs, then advance the model.
  task automatic cycle(input bit r, input bit i_if, input bit i_id, input bit i_ex,
                       input bit i_mem, input bit fr, input logic [31:0] npc);
    exp_t e;
    int   s;
    @(posedge clk);
    #1;
    rst                = r;
    bus.if_stallreq_i  = i_if;
    bus.id_stallreq_i  = i_id;
    bus.ex_stallreq_i  = i_ex;
    bus.mem_stallreq_i = i_mem;
    bus.flush_req_i    = fr;
    bus.new_pc_i       = npc;

    s = 0;
    if (m_flush_left == 0) begin
      if (i_mem)     s = 'b011111;
      else if (i_ex) s = 'b001111;
      else if (i_id) s = 'b000111;
      else if (i_if) s = 'b000011;
    end
    e.chk   = m_valid;
    e.stall = 32'(s);
    e.flush = (m_flush_left > 0) ? 32'd1 : 32'd0;
    e.pc    = (m_flush_left > 0) ? m_pc : 32'd0;
    e.tmo   = m_tmo ? 32'd1 : 32'd0;
    e.sc    = PERF ? m_sc : 32'd0;
    e.fc    = PERF ? m_fc : 32'd0;
    sb_q.push_back(e);

    if (r) begin
      m_valid      = 1'b1;
      m_flush_left = 0;
      m_run        = 0;
      m_tmo        = 1'b0;
      m_pc         = '0;
      m_sc         = '0;
      m_fc         = '0;
    end else begin
      if (s != 0) begin
        if (m_run < STALL_TIMEOUT) m_run++;
        if (m_run >= STALL_TIMEOUT) m_tmo = 1'b1;
        m_sc = m_sc + 32'd1;
      end else begin
        m_run = 0;
      end
      if (m_flush_left > 0) m_flush_left--;
      else if (fr) begin
        m_flush_left = FLUSH_LEN;
        m_pc         = npc;
        m_fc         = m_fc + 32'd1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk) begin
          check("stall_o", 32'(bus.stall_o), e.stall);
          check("flush_o", 32'(bus.flush_o), e.flush);
          check("new_pc_o", bus.new_pc_o, e.pc);
          check("stall_timeout_o", 32'(bus.stall_timeout_o), e.tmo);
          check("stall_cycles_o", bus.stall_cycles_o, e.sc);
          check("flush_count_o", bus.flush_count_o, e.fc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    bus.if_stallreq_i  = 1'b0;
    bus.id_stallreq_i  = 1'b0;
    bus.ex_stallreq_i  = 1'b0;
    bus.mem_stallreq_i = 1'b0;
    bus.flush_req_i    = 1'b0;
    bus.new_pc_i       = 32'h0;

    cycle(1, 0, 0, 0, 0, 0, 32'h0);
    cycle(1, 0, 0, 0, 0, 0, 32'h0);
    idle(2);

    // single-cycle load-use
    cycle(0, 0, 1, 0, 0, 0, 32'h0);
    idle(2);

    // EX and ID together for three cycles
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 1, 0, 0, 32'h0);
    idle(2);

    // flush with simultaneous MEM stall
    cycle(0, 0, 0, 0, 1, 1, 32'hBFC0_0380);
    idle(3);

    // second flush request inside FLUSH is dropped
    cycle(0, 0, 0, 0, 0, 1, 32'h8000_0180);
    cycle(0, 1, 1, 1, 1, 1, 32'h1234_5678);
    cycle(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    idle(3);

    // watchdog: long EX stall, just below then past the limit
    for (int k = 0; k < STALL_TIMEOUT - 1; k++) cycle(0, 0, 0, 1, 0, 0, 32'h0);
    idle(2);
    for (int k = 0; k < STALL_TIMEOUT + 4; k++) cycle(0, 0, 0, 1, 0, 0, 32'h0);
    idle(3);
    cycle(1, 0, 0, 0, 0, 0, 32'h0);
    idle(2);

    // reset on the first FLUSH cycle
    cycle(0, 0, 0, 0, 0, 1, 32'hBFC0_0000);
    cycle(1, 0, 0, 0, 0, 0, 32'h0);
    idle(3);

    // random traffic
    for (int k = 0; k < 2000; k++) begin
      cycle($urandom_range(99) < 1,
            $urandom_range(99) < 30,
            $urandom_range(99) < 25,
            $urandom_range(99) < 25,
            $urandom_range(99) < 20,
            $urandom_range(99) < 8,
            $urandom);
    end
    idle(2);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
